// File: rtl/fir_pkg.sv
// ============================================================================
// Module      : fir_pkg
// Description : Shared FIR definitions. Holds the tap count, the default
//               sample/coefficient/product widths and the tap-index to
//               bit-slice convention used by the tap multiplier and the
//               sum tree.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_pkg;

  localparam int NUM_TAPS    = 8;
  localparam int TAP_IDX_W   = 3;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_COEF_W  = 16;
  localparam int DEF_PROD_W  = DEF_DATA_W + DEF_COEF_W;

  // Tap i occupies bits [width*(i+1)-1 -: width] of a flattened word;
  // this returns the LSB position of that slice.
  function automatic int tap_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_coef_bank.sv
// ============================================================================
// Module      : fir_coef_bank
// Description : Double-buffered coefficient store. Writes land in a shadow
//               bank; a commit copies the whole shadow bank into the active
//               bank in one edge.
// Revision    : 1.0 - initial release
// Ports       : clk          - clock, rising edge
//               rst_n        - synchronous active-low reset (clears both banks)
//               we           - write data into shadow[addr]
//               addr         - shadow index 0..NUM_TAPS-1
//               data         - signed coefficient
//               commit       - copy shadow -> active
//               active_flat  - active coefficients, tap i at slice i
// ============================================================================
`default_nettype none

module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int COEF_W = DEF_COEF_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [TAP_IDX_W-1:0]       addr,
  input  logic [COEF_W-1:0]          data,
  input  logic                       commit,
  output logic [NUM_TAPS*COEF_W-1:0] active_flat
);

  logic [COEF_W-1:0] shadow [NUM_TAPS];
  logic [COEF_W-1:0] active [NUM_TAPS];

  // Non-blocking semantics make a same-edge commit copy the pre-write
  // shadow contents; the write still lands and waits for a later commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (we) begin
        shadow[addr] <= data;
      end
      if (commit) begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_flat
    assign active_flat[tap_lsb(i, COEF_W) +: COEF_W] = active[i];
  end

endmodule

`default_nettype wire

// File: rtl/fir_tap_multiplier.sv
// ============================================================================
// Module      : fir_tap_multiplier
// Description : FIR front half: 8-deep sample delay line, double-buffered
//               coefficient bank and one registered full-precision multiply
//               per tap. Products are flattened for the downstream sum tree.
// Revision    : 1.0 - initial release
// Ports       : clk          - clock, rising edge
//               rst_n        - synchronous active-low reset
//               in_valid     - in_sample is a new sample this cycle
//               in_sample    - signed input sample
//               flush        - clear delay line, fill count and valid pipe
//               coef_we      - write coef_data to shadow[coef_addr]
//               coef_addr    - shadow index
//               coef_data    - signed coefficient
//               coef_commit  - copy shadow bank to active bank
//               prod_flat    - product i at [PROD_W*(i+1)-1 -: PROD_W]
//               out_valid    - prod_flat holds a new product set
//               primed       - delay line holds NUM_TAPS real samples
// ============================================================================
`default_nettype none

module fir_tap_multiplier
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int PROD_W = DATA_W + COEF_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic signed [DATA_W-1:0]    in_sample,
  input  logic                        flush,
  input  logic                        coef_we,
  input  logic [TAP_IDX_W-1:0]        coef_addr,
  input  logic [COEF_W-1:0]           coef_data,
  input  logic                        coef_commit,
  output logic [NUM_TAPS*PROD_W-1:0]  prod_flat,
  output logic                        out_valid,
  output logic                        primed
);

  localparam logic [3:0] FULL_COUNT = 4'(NUM_TAPS);

  logic signed [DATA_W-1:0] taps [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_next [NUM_TAPS];
  logic [NUM_TAPS*COEF_W-1:0] coef_flat;
  logic [3:0] count;
  logic       v1;

  fir_coef_bank #(
    .COEF_W (COEF_W)
  ) u_coef_bank (
    .clk         (clk),
    .rst_n       (rst_n),
    .we          (coef_we),
    .addr        (coef_addr),
    .data        (coef_data),
    .commit      (coef_commit),
    .active_flat (coef_flat)
  );

  // Both operands are sign-extended to PROD_W before multiplying, so the
  // full signed product is kept with no truncation.
  for (genvar i = 0; i < NUM_TAPS; i++) begin : g_mul
    logic signed [COEF_W-1:0] coef_i;
    assign coef_i       = coef_flat[tap_lsb(i, COEF_W) +: COEF_W];
    assign prod_next[i] = PROD_W'(coef_i) * PROD_W'(taps[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        taps[i] <= '0;
      end
      count     <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
      prod_flat <= '0;
    end else if (flush) begin
      // Flush drops any same-cycle sample and in-flight valids; the last
      // product set stays on prod_flat.
      for (int i = 0; i < NUM_TAPS; i++) begin
        taps[i] <= '0;
      end
      count     <= '0;
      v1        <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) begin
        taps[0] <= in_sample;
        for (int i = 1; i < NUM_TAPS; i++) begin
          taps[i] <= taps[i-1];
        end
        if (count != FULL_COUNT) begin
          count <= count + 4'd1;
        end
      end
      v1        <= in_valid;
      out_valid <= v1;
      if (v1) begin
        for (int i = 0; i < NUM_TAPS; i++) begin
          prod_flat[tap_lsb(i, PROD_W) +: PROD_W] <= prod_next[i];
        end
      end
    end
  end

  assign primed = (count == FULL_COUNT);

endmodule

`default_nettype wire

// File: tb/tb_fir_tap_multiplier.sv
// ============================================================================
// Module      : tb_fir_tap_multiplier
// Description : Self-checking bench for fir_tap_multiplier. A behavioural
//               model (sample history queue plus coefficient arrays) predicts
//               every cycle; tables and short sequences cover corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fir_tap_multiplier;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [15:0]  in_sample;
  logic         flush;
  logic         coef_we;
  logic [2:0]   coef_addr;
  logic [15:0]  coef_data;
  logic         coef_commit;
  logic [255:0] prod_flat;
  logic         out_valid;
  logic         primed;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int           hist[$];     // accepted samples, newest first, at most 8
  int           shadow[8];
  int           active[8];
  bit           pend;        // a sample was accepted at the previous edge
  bit           ov;
  logic [255:0] mprod;

  typedef struct {
    logic [15:0] coef;
    logic [15:0] sample;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[6];

  fir_tap_multiplier dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_sample   (in_sample),
    .flush       (flush),
    .coef_we     (coef_we),
    .coef_addr   (coef_addr),
    .coef_data   (coef_data),
    .coef_commit (coef_commit),
    .prod_flat   (prod_flat),
    .out_valid   (out_valid),
    .primed      (primed)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit iv, input logic [15:0] s, input bit fl,
                            input bit we, input logic [2:0] a, input logic [15:0] d, input bit cm);
    longint t;
    longint p;
    if (!r) begin
      hist.delete();
      for (int i = 0; i < 8; i++) begin
        shadow[i] = 0;
        active[i] = 0;
      end
      pend  = 0;
      ov    = 0;
      mprod = '0;
    end else begin
      if (fl) begin
        hist.delete();
        pend = 0;
        ov   = 0;
      end else begin
        if (pend) begin
          for (int i = 0; i < 8; i++) begin
            t = (i < hist.size()) ? longint'(hist[i]) : 64'sd0;
            p = longint'(active[i]) * t;
            mprod[i*32 +: 32] = p[31:0];
          end
        end
        ov   = pend;
        pend = iv;
        if (iv) begin
          hist.push_front(int'($signed(s)));
          if (hist.size() > 8) void'(hist.pop_back());
        end
      end
      if (cm) active = shadow;
      if (we) shadow[a] = int'($signed(d));
    end
  endtask

  task automatic step(input bit r, input bit iv, input logic [15:0] s, input bit fl,
                      input bit we, input logic [2:0] a, input logic [15:0] d, input bit cm);
    rst_n       = r;
    in_valid    = iv;
    in_sample   = s;
    flush       = fl;
    coef_we     = we;
    coef_addr   = a;
    coef_data   = d;
    coef_commit = cm;
    @(posedge clk);
    model_edge(r, iv, s, fl, we, a, d, cm);
    #1;
    check("model_out_valid", 256'(out_valid), 256'(ov));
    check("model_primed", 256'(primed), 256'(hist.size() == 8));
    check("model_prod_flat", prod_flat, mprod);
  endtask

  initial begin
    logic [255:0] all10;
    logic [255:0] all15;
    bit           ov_pat[5];

    tbl[0] = '{16'h8000, 16'h8000, 32'h40000000};
    tbl[1] = '{16'h7FFF, 16'h8000, 32'hC0008000};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 32'h00000001};
    tbl[3] = '{16'h7FFF, 16'h7FFF, 32'h3FFF0001};
    tbl[4] = '{16'h8000, 16'h0001, 32'hFFFF8000};
    tbl[5] = '{16'h8000, 16'h7FFF, 32'hC0008000};

    for (int k = 0; k < 8; k++) begin
      all10[k*32 +: 32] = 32'd10;
      all15[k*32 +: 32] = 32'd15;
    end

    // Reset held with a live sample on the input
    repeat (2) step(0, 1, 16'd100, 0, 0, 3'd0, 16'd0, 0);
    check("rst_prod", prod_flat, 256'd0);
    check("rst_out_valid", 256'(out_valid), 256'd0);
    check("rst_primed", 256'(primed), 256'd0);

    // Coefficients come out of reset as zero: products stay zero
    repeat (10) step(1, 1, 16'h1234, 0, 0, 3'd0, 16'd0, 0);
    check("rst_coef_zero", prod_flat, 256'd0);

    // Impulse walk with coef i = i+1
    for (int k = 0; k < 8; k++) step(1, 0, 16'd0, 0, 1, 3'(k), 16'(k + 1), 0);
    step(1, 0, 16'd0, 0, 0, 3'd0, 16'd0, 1);
    step(1, 0, 16'd0, 1, 0, 3'd0, 16'd0, 0);
    for (int j = 0; j < 8; j++) begin
      step(1, 1, (j == 0) ? 16'd1 : 16'd0, 0, 0, 3'd0, 16'd0, 0);
      if (j > 0) check("impulse", 256'(prod_flat[(j-1)*32 +: 32]), 256'(j));
      if (j == 6) check("primed_early", 256'(primed), 256'd0);
      if (j == 7) check("primed_8th", 256'(primed), 256'd1);
    end
    step(1, 0, 16'd0, 0, 0, 3'd0, 16'd0, 0);
    check("impulse_last", 256'(prod_flat[7*32 +: 32]), 256'd8);

    // Sign extremes through tap 0
    for (int v = 0; v < 6; v++) begin
      step(1, 0, 16'd0, 0, 1, 3'd0, tbl[v].coef, 0);
      step(1, 0, 16'd0, 0, 0, 3'd0, 16'd0, 1);
      step(1, 1, tbl[v].sample, 0, 0, 3'd0, 16'd0, 0);
      step(1, 0, 16'd0, 0, 0, 3'd0, 16'd0, 0);
      check("sign_vec", 256'(prod_flat[31:0]), 256'(tbl[v].exp));
    end

    // Double buffer: active 2, shadow 3 while streaming 5
    for (int k = 0; k < 8; k++) step(1, 0, 16'd0, 0, 1, 3'(k), 16'd2, 0);
    step(1, 0, 16'd0, 0, 0, 3'd0, 16'd0, 1);
    repeat (9) step(1, 1, 16'd5, 0, 0, 3'd0, 16'd0, 0);
    for (int k = 0; k < 8; k++) begin
      step(1, 1, 16'd5, 0, 1, 3'(k), 16'd3, 0);
      check("dbuf_pre_commit", prod_flat, all10);
    end
    step(1, 1, 16'd5, 0, 0, 3'd0, 16'd0, 1);
    check("dbuf_commit_edge", prod_flat, all10);
    step(1, 1, 16'd5, 0, 0, 3'd0, 16'd0, 0);
    check("dbuf_after", prod_flat, all15);

    // Write and commit in the same cycle
    step(1, 1, 16'd1, 0, 1, 3'd0, 16'd7, 1);
    step(1, 1, 16'd1, 0, 0, 3'd0, 16'd0, 0);
    check("cw_old_value", 256'(prod_flat[31:0]), 256'd3);
    step(1, 1, 16'd1, 0, 0, 3'd0, 16'd0, 1);
    step(1, 1, 16'd1, 0, 0, 3'd0, 16'd0, 0);
    check("cw_new_value", 256'(prod_flat[31:0]), 256'd7);

    // Flush beats in_valid, then gapped samples
    check("flush_pre_primed", 256'(primed), 256'd1);
    step(1, 1, 16'd9, 1, 0, 3'd0, 16'd0, 0);
    check("flush_primed", 256'(primed), 256'd0);
    check("flush_out_valid", 256'(out_valid), 256'd0);
    ov_pat = '{0, 1, 0, 1, 0};
    for (int k = 0; k < 5; k++) begin
      case (k)
        0:       step(1, 1, 16'd4, 0, 0, 3'd0, 16'd0, 0);
        2:       step(1, 1, 16'd6, 0, 0, 3'd0, 16'd0, 0);
        default: step(1, 0, 16'd0, 0, 0, 3'd0, 16'd0, 0);
      endcase
      check("gap_out_valid", 256'(out_valid), 256'(ov_pat[k]));
      if (k == 1) check("flush_drop_prod", 256'(prod_flat[31:0]), 256'd28);
    end

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 9) < 7),
           16'($urandom),
           ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 9) < 3),
           3'($urandom_range(0, 7)),
           16'($urandom),
           ($urandom_range(0, 9) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
